// File: rtl/ysyx_22050550_wb_pkg.sv
// Shared types and defaults for the writeback arbiter.
// Source IDs and the buffered entry layout used by the slots and the top level.
package ysyx_22050550_wb_pkg;

  localparam int XLEN_DEF = 64;
  localparam int AW_DEF   = 5;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [AW_DEF-1:0]   waddr;
    logic                wen;
    logic [XLEN_DEF-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_22050550_wb_slot.sv
// One-entry writeback buffer for a single source.
// Accepts on valid&ready and can refill in the same edge it is drained.
module ysyx_22050550_wb_slot
  import ysyx_22050550_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid,
  output logic            ready,
  input  logic [AW-1:0]   waddr,
  input  logic            wen,
  input  logic [XLEN-1:0] wdata,
  input  logic            drain,
  output logic            slot_valid,
  output logic [AW-1:0]   slot_waddr,
  output logic            slot_wen,
  output logic [XLEN-1:0] slot_wdata
);

  logic            valid_r;
  logic [AW-1:0]   waddr_r;
  logic            wen_r;
  logic [XLEN-1:0] wdata_r;
  logic            load_s;

  // Ready is forced low while reset is held so upstream sees no acceptance.
  assign ready  = reset & (~valid_r | drain);
  assign load_s = valid & ready;

  // Occupancy flag: a load wins over a drain so a same-edge refill keeps the slot full.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_r <= 1'b0;
    end else if (load_s) begin
      valid_r <= 1'b1;
    end else if (drain) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Payload register: sampled only on a handshake.
  always_ff @(posedge clock) begin
    if (!reset) begin
      waddr_r <= {AW{1'b0}};
      wen_r   <= 1'b0;
      wdata_r <= {XLEN{1'b0}};
    end else if (load_s) begin
      waddr_r <= waddr;
      wen_r   <= wen;
      wdata_r <= wdata;
    end else begin
      waddr_r <= waddr_r;
      wen_r   <= wen_r;
      wdata_r <= wdata_r;
    end
  end

  assign slot_valid = valid_r;
  assign slot_waddr = waddr_r;
  assign slot_wen   = wen_r;
  assign slot_wdata = wdata_r;

endmodule

// File: rtl/ysyx_22050550_wb_arbiter.sv
// Round-robin writeback arbiter between EXU and LSU for the shared regfile/scoreboard port.
// Holds one entry per source, drives registered write strobes and counts retired instructions.
module ysyx_22050550_wb_arbiter
  import ysyx_22050550_wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int AW    = AW_DEF,
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_EXU_valid,
  output logic             io_EXU_ready,
  input  logic [AW-1:0]    io_EXU_waddr,
  input  logic             io_EXU_wen,
  input  logic [XLEN-1:0]  io_EXU_wdata,
  input  logic             io_LSU_valid,
  output logic             io_LSU_ready,
  input  logic [AW-1:0]    io_LSU_waddr,
  input  logic             io_LSU_wen,
  input  logic [XLEN-1:0]  io_LSU_wdata,
  output logic             io_WBU_wen,
  output logic [AW-1:0]    io_WBU_waddr,
  output logic [XLEN-1:0]  io_WBU_wdata,
  output logic             io_commit,
  output logic [CNT_W-1:0] io_commit_cnt,
  output logic             io_idle
);

  // x0 is hardwired, so an entry targeting it retires without a write strobe.
  function automatic logic writes_reg(input logic wen, input logic [AW-1:0] waddr);
    return wen & (waddr != {AW{1'b0}});
  endfunction

  logic            exu_slot_valid_s;
  logic [AW-1:0]   exu_slot_waddr_s;
  logic            exu_slot_wen_s;
  logic [XLEN-1:0] exu_slot_wdata_s;
  logic            lsu_slot_valid_s;
  logic [AW-1:0]   lsu_slot_waddr_s;
  logic            lsu_slot_wen_s;
  logic [XLEN-1:0] lsu_slot_wdata_s;

  logic            grant_valid_s;
  wb_src_e         grant_src_s;
  logic            exu_drain_s;
  logic            lsu_drain_s;
  logic [AW-1:0]   sel_waddr_s;
  logic            sel_wen_s;
  logic [XLEN-1:0] sel_wdata_s;

  wb_src_e         last_grant_r;
  logic            wbu_wen_r;
  logic [AW-1:0]   wbu_waddr_r;
  logic [XLEN-1:0] wbu_wdata_r;
  logic            commit_r;
  logic [CNT_W-1:0] commit_cnt_r;

  ysyx_22050550_wb_slot #(.XLEN(XLEN), .AW(AW)) u_exu_slot (
    .clock      (clock),
    .reset      (reset),
    .valid      (io_EXU_valid),
    .ready      (io_EXU_ready),
    .waddr      (io_EXU_waddr),
    .wen        (io_EXU_wen),
    .wdata      (io_EXU_wdata),
    .drain      (exu_drain_s),
    .slot_valid (exu_slot_valid_s),
    .slot_waddr (exu_slot_waddr_s),
    .slot_wen   (exu_slot_wen_s),
    .slot_wdata (exu_slot_wdata_s)
  );

  ysyx_22050550_wb_slot #(.XLEN(XLEN), .AW(AW)) u_lsu_slot (
    .clock      (clock),
    .reset      (reset),
    .valid      (io_LSU_valid),
    .ready      (io_LSU_ready),
    .waddr      (io_LSU_waddr),
    .wen        (io_LSU_wen),
    .wdata      (io_LSU_wdata),
    .drain      (lsu_drain_s),
    .slot_valid (lsu_slot_valid_s),
    .slot_waddr (lsu_slot_waddr_s),
    .slot_wen   (lsu_slot_wen_s),
    .slot_wdata (lsu_slot_wdata_s)
  );

  // Grant selection: a lone valid slot wins; on conflict the source not granted last wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_src_s   = SRC_EXU;
    case ({exu_slot_valid_s, lsu_slot_valid_s})
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_EXU;
      end
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_LSU;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_src_s   = (last_grant_r == SRC_EXU) ? SRC_LSU : SRC_EXU;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_src_s   = SRC_EXU;
      end
    endcase
  end

  assign exu_drain_s = grant_valid_s & (grant_src_s == SRC_EXU);
  assign lsu_drain_s = grant_valid_s & (grant_src_s == SRC_LSU);

  // Payload mux for the granted source.
  always_comb begin
    sel_waddr_s = exu_slot_waddr_s;
    sel_wen_s   = exu_slot_wen_s;
    sel_wdata_s = exu_slot_wdata_s;
    if (grant_src_s == SRC_LSU) begin
      sel_waddr_s = lsu_slot_waddr_s;
      sel_wen_s   = lsu_slot_wen_s;
      sel_wdata_s = lsu_slot_wdata_s;
    end else begin
      sel_waddr_s = exu_slot_waddr_s;
      sel_wen_s   = exu_slot_wen_s;
      sel_wdata_s = exu_slot_wdata_s;
    end
  end

  // Round-robin pointer: LSU after reset so EXU wins the first conflict.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant_r <= SRC_LSU;
    end else if (grant_valid_s) begin
      last_grant_r <= grant_src_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Output stage: loaded with the granted entry, cleared in cycles without a grant.
  always_ff @(posedge clock) begin
    if (!reset) begin
      commit_r    <= 1'b0;
      wbu_wen_r   <= 1'b0;
      wbu_waddr_r <= {AW{1'b0}};
      wbu_wdata_r <= {XLEN{1'b0}};
    end else if (grant_valid_s) begin
      commit_r    <= 1'b1;
      wbu_wen_r   <= writes_reg(sel_wen_s, sel_waddr_s);
      wbu_waddr_r <= sel_waddr_s;
      wbu_wdata_r <= sel_wdata_s;
    end else begin
      commit_r    <= 1'b0;
      wbu_wen_r   <= 1'b0;
      wbu_waddr_r <= {AW{1'b0}};
      wbu_wdata_r <= {XLEN{1'b0}};
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clock) begin
    if (!reset) begin
      commit_cnt_r <= {CNT_W{1'b0}};
    end else if (commit_r) begin
      commit_cnt_r <= commit_cnt_r + CNT_W'(1);
    end else begin
      commit_cnt_r <= commit_cnt_r;
    end
  end

  assign io_WBU_wen    = wbu_wen_r;
  assign io_WBU_waddr  = wbu_waddr_r;
  assign io_WBU_wdata  = wbu_wdata_r;
  assign io_commit     = commit_r;
  assign io_commit_cnt = commit_cnt_r;
  // Reported idle while reset is held, even before the first reset edge clears the flops.
  assign io_idle       = ~reset | (~exu_slot_valid_s & ~lsu_slot_valid_s & ~commit_r);

endmodule

// File: tb/tb_ysyx_22050550_wb_arbiter.sv
// Self-checking bench for the writeback arbiter: directed vector table, hand sequences,
// and a randomized run against a queue-based scoreboard.
module tb_ysyx_22050550_wb_arbiter;
  import ysyx_22050550_wb_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ev = 1'b0, lv = 1'b0, ew = 1'b0, lw = 1'b0;
  logic [4:0]  ea = 5'd0, la = 5'd0;
  logic [63:0] ed = 64'd0, ld = 64'd0;
  logic        er, lr, wen, commit, idle;
  logic [4:0]  waddr;
  logic [63:0] wdata, cnt;
  logic        er4, lr4, wen4, commit4, idle4;
  logic [4:0]  waddr4;
  logic [63:0] wdata4;
  logic [3:0]  cnt4;

  always #5 clock = ~clock;

  ysyx_22050550_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .io_EXU_valid(ev), .io_EXU_ready(er), .io_EXU_waddr(ea), .io_EXU_wen(ew), .io_EXU_wdata(ed),
    .io_LSU_valid(lv), .io_LSU_ready(lr), .io_LSU_waddr(la), .io_LSU_wen(lw), .io_LSU_wdata(ld),
    .io_WBU_wen(wen), .io_WBU_waddr(waddr), .io_WBU_wdata(wdata),
    .io_commit(commit), .io_commit_cnt(cnt), .io_idle(idle)
  );

  ysyx_22050550_wb_arbiter #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .io_EXU_valid(ev), .io_EXU_ready(er4), .io_EXU_waddr(ea), .io_EXU_wen(ew), .io_EXU_wdata(ed),
    .io_LSU_valid(lv), .io_LSU_ready(lr4), .io_LSU_waddr(la), .io_LSU_wen(lw), .io_LSU_wdata(ld),
    .io_WBU_wen(wen4), .io_WBU_waddr(waddr4), .io_WBU_wdata(wdata4),
    .io_commit(commit4), .io_commit_cnt(cnt4), .io_idle(idle4)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic ev; logic [4:0] ea; logic ew; logic [63:0] ed;
    logic lv; logic [4:0] la; logic lw; logic [63:0] ld;
    logic x_er; logic x_lr;
    logic x_wen; logic [4:0] x_wa; logic [63:0] x_wd; logic x_com; logic [63:0] x_cnt;
  } vec_t;

  typedef struct {
    wb_entry_t e;
    int        c;
  } pend_t;

  vec_t  tbl[8];
  pend_t qe[$];
  pend_t ql[$];
  pend_t p;
  int    cyc = 0;
  int    ref_cnt = 0;
  logic  e_hold = 1'b0, l_hold = 1'b0;
  logic  hs_e, hs_l;

  task automatic idle_inputs();
    ev = 1'b0; lv = 1'b0;
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    @(posedge clock); #1;
    if (chk) begin
      check("rst_exu_ready", er, 1'b0);
      check("rst_lsu_ready", lr, 1'b0);
      check("rst_wen", wen, 1'b0);
      check("rst_waddr", waddr, 5'd0);
      check("rst_wdata", wdata, 64'd0);
      check("rst_commit", commit, 1'b0);
      check("rst_cnt", cnt, 64'd0);
      check("rst_idle", idle, 1'b1);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  // One randomized cycle; scoreboard tracks entries accepted but not yet on the output stage.
  task automatic rnd_step(input bit gen);
    @(negedge clock);
    if (!e_hold) begin
      ev = gen ? 1'($urandom_range(0, 1)) : 1'b0;
      ea = 5'($urandom); ew = 1'($urandom);
      ed = {1'b0, 31'($urandom), 32'($urandom)};
    end
    if (!l_hold) begin
      lv = gen ? 1'($urandom_range(0, 1)) : 1'b0;
      la = 5'($urandom); lw = 1'($urandom);
      ld = {1'b1, 31'($urandom), 32'($urandom)};
    end
    #1;
    hs_e = ev & er;
    hs_l = lv & lr;
    @(posedge clock); #1;
    cyc++;
    if (hs_e) qe.push_back('{e: '{waddr: ea, wen: ew, wdata: ed}, c: cyc});
    if (hs_l) ql.push_back('{e: '{waddr: la, wen: lw, wdata: ld}, c: cyc});
    e_hold = ev & ~hs_e;
    l_hold = lv & ~hs_l;
    check("rnd_cnt", cnt, 64'(ref_cnt));
    if (commit) begin
      if (wdata[63] ? (ql.size() == 0) : (qe.size() == 0)) begin
        check("rnd_spurious_commit", 1'b1, 1'b0);
      end else begin
        p = wdata[63] ? ql.pop_front() : qe.pop_front();
        check("rnd_waddr", waddr, p.e.waddr);
        check("rnd_wen", wen, p.e.wen & (p.e.waddr != 5'd0));
        check("rnd_latency_ok", 64'((cyc - p.c == 1) || (cyc - p.c == 2)), 64'd1);
      end
      ref_cnt++;
    end
    check("rnd_idle", idle, (qe.size() == 0) && (ql.size() == 0) && !commit);
  endtask

  int   ei, li, ncom, prev_src, src, first_c, last_c, base;
  logic [31:0] seen;

  initial begin
    // Contested first conflict, then store and rd=x0 entries.
    tbl[0] = '{1'b1, 5'd3, 1'b1, 64'h33, 1'b1, 5'd7, 1'b1, 64'h77, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'd0};
    tbl[1] = '{1'b0, 5'd0, 1'b0, 64'h0,  1'b0, 5'd0, 1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 5'd3, 64'h33, 1'b1, 64'd0};
    tbl[2] = '{1'b0, 5'd0, 1'b0, 64'h0,  1'b0, 5'd0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 5'd7, 64'h77, 1'b1, 64'd1};
    tbl[3] = '{1'b0, 5'd0, 1'b0, 64'h0,  1'b0, 5'd0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'd2};
    tbl[4] = '{1'b0, 5'd0, 1'b0, 64'h0,  1'b1, 5'd9, 1'b0, 64'h5,  1'b1, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'd2};
    tbl[5] = '{1'b1, 5'd0, 1'b1, 64'hAB, 1'b0, 5'd0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 5'd9, 64'h5,  1'b1, 64'd2};
    tbl[6] = '{1'b0, 5'd0, 1'b0, 64'h0,  1'b0, 5'd0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 5'd0, 64'hAB, 1'b1, 64'd3};
    tbl[7] = '{1'b0, 5'd0, 1'b0, 64'h0,  1'b0, 5'd0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'd4};

    #1;
    check("pre_edge_idle", idle, 1'b1);
    do_reset(1'b1);

    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      ev = tbl[i].ev; ea = tbl[i].ea; ew = tbl[i].ew; ed = tbl[i].ed;
      lv = tbl[i].lv; la = tbl[i].la; lw = tbl[i].lw; ld = tbl[i].ld;
      #1;
      check("tbl_exu_ready", er, tbl[i].x_er);
      check("tbl_lsu_ready", lr, tbl[i].x_lr);
      @(posedge clock); #1;
      check("tbl_wen", wen, tbl[i].x_wen);
      check("tbl_waddr", waddr, tbl[i].x_wa);
      check("tbl_wdata", wdata, tbl[i].x_wd);
      check("tbl_commit", commit, tbl[i].x_com);
      check("tbl_cnt", cnt, tbl[i].x_cnt);
    end

    // Single uncontested EXU write: strobe after edge t+1, count at edge t+2.
    @(negedge clock);
    ev = 1'b1; ea = 5'd5; ew = 1'b1; ed = 64'hDEAD;
    @(posedge clock); #1;
    check("single_commit_t", commit, 1'b0);
    @(negedge clock);
    idle_inputs();
    @(posedge clock); #1;
    check("single_wen", wen, 1'b1);
    check("single_waddr", waddr, 5'd5);
    check("single_wdata", wdata, 64'hDEAD);
    check("single_cnt_before", cnt, 64'd4);
    @(negedge clock);
    @(posedge clock); #1;
    check("single_cnt_after", cnt, 64'd5);
    check("single_wen_drop", wen, 1'b0);

    // Both sources streaming: grants must alternate with no loss or duplication.
    ei = 0; li = 0; ncom = 0; prev_src = -1; seen = 32'd0; base = 5;
    for (int k = 0; k < 60 && ncom < 20; k++) begin
      @(negedge clock);
      ev = (ei < 10); ea = 5'(ei + 1);  ew = 1'b1; ed = 64'(ei + 100);
      lv = (li < 10); la = 5'(li + 11); lw = 1'b1; ld = 64'(li + 200);
      #1;
      hs_e = ev & er; hs_l = lv & lr;
      @(posedge clock); #1;
      if (hs_e) ei++;
      if (hs_l) li++;
      if (commit) begin
        src = (waddr > 5'd10) ? 1 : 0;
        if (prev_src >= 0) check("stream_alternate", 64'(src != prev_src), 64'd1);
        check("stream_dup", 64'(seen[waddr]), 64'd0);
        seen[waddr] = 1'b1;
        prev_src = src;
        ncom++;
      end
    end
    idle_inputs();
    check("stream_commits", 64'(ncom), 64'd20);
    check("stream_all_seen", seen, 32'h001F_FFFE);
    @(posedge clock); #1;
    check("stream_cnt", cnt, 64'(base + 20));

    // Counter wrap on the CNT_W=4 build, with one-per-cycle single-source throughput.
    do_reset(1'b0);
    ei = 0; ncom = 0; first_c = 0; last_c = 0;
    for (int k = 0; k < 50 && ncom < 17; k++) begin
      @(negedge clock);
      ev = (ei < 17); ea = 5'(ei + 1); ew = 1'b1; ed = 64'(ei);
      #1;
      hs_e = ev & er;
      @(posedge clock); #1;
      if (hs_e) ei++;
      if (commit) begin
        if (ncom == 0) first_c = k;
        last_c = k;
        ncom++;
      end
    end
    idle_inputs();
    check("wrap_commits", 64'(ncom), 64'd17);
    check("wrap_throughput", 64'(last_c - first_c), 64'd16);
    @(posedge clock); #1;
    check("wrap_cnt64", cnt, 64'd17);
    check("wrap_cnt4", 64'(cnt4), 64'd1);

    // Reset while both slots hold entries.
    @(negedge clock);
    ev = 1'b1; ea = 5'd12; ew = 1'b1; ed = 64'h12;
    lv = 1'b1; la = 5'd13; lw = 1'b1; ld = 64'h13;
    @(posedge clock); #1;
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    @(posedge clock); #1;
    check("mrst_wen", wen, 1'b0);
    check("mrst_cnt", cnt, 64'd0);
    check("mrst_idle", idle, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("mrst_exu_ready", er, 1'b1);
    check("mrst_lsu_ready", lr, 1'b1);
    check("mrst_idle_after", idle, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check("mrst_no_strobe", {wen, commit}, 2'b00);
    end

    // Randomized traffic against the scoreboard, then drain.
    do_reset(1'b0);
    qe.delete(); ql.delete(); ref_cnt = 0; cyc = 0; e_hold = 1'b0; l_hold = 1'b0;
    for (int k = 0; k < 400; k++) rnd_step(1'b1);
    for (int k = 0; k < 6; k++) rnd_step(1'b0);
    check("rnd_drained", 64'(qe.size() + ql.size()), 64'd0);
    check("rnd_final_cnt", cnt, 64'(ref_cnt));
    check("rnd_final_cnt4", 64'(cnt4), 64'(ref_cnt % 16));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
